// File: rtl/temporizador_jogada.sv
// Per-move time-limit controller: drives the modulo-M counter and turns its flags into warning/timeout/accepted pulses.
// Optional pause input under TEMPORIZADOR_PAUSA_EN; Moore outputs, move accepted one edge after its rising edge.
module temporizador_jogada #(
  parameter int MAX_FALTAS = 3,
  parameter int NF         = 2
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          iniciar,
  input  logic          jogada,
  input  logic          fim_t,
  input  logic          meio_t,
`ifdef TEMPORIZADOR_PAUSA_EN
  input  logic          pausa,
`endif
  output logic          zera_t,
  output logic          conta_t,
  output logic          pronto,
  output logic          alerta,
  output logic          jogada_ok,
  output logic          timeout,
  output logic          fim_jogo,
  output logic [NF-1:0] faltas,
  output logic [2:0]    db_estado
);

  typedef enum logic [2:0] {
    INICIAL  = 3'd0,
    PREPARA  = 3'd1,
    ESPERA   = 3'd2,
    REGISTRA = 3'd3,
    ESGOTADO = 3'd4,
    FIM_JOGO = 3'd5
  } estado_t;

  localparam logic [NF:0] C_MAX = MAX_FALTAS[NF:0];

  estado_t       r_estado;
  estado_t       w_proximo;
  logic          r_jogada_d;
  logic          r_alerta;
  logic [NF-1:0] r_faltas;
  logic [NF:0]   w_faltas_mais;
  logic          w_mov;
  logic          w_pausa;
  logic          w_reinicia;

`ifdef TEMPORIZADOR_PAUSA_EN
  assign w_pausa = pausa;
`else
  assign w_pausa = 1'b0;
`endif

  assign w_mov         = jogada & ~r_jogada_d;
  assign w_faltas_mais = {1'b0, r_faltas} + {{NF{1'b0}}, 1'b1};
  assign w_reinicia    = iniciar & ((r_estado == INICIAL) | (r_estado == FIM_JOGO));

  always_comb begin
    w_proximo = r_estado;
    zera_t    = 1'b0;
    conta_t   = 1'b0;
    pronto    = 1'b0;
    jogada_ok = 1'b0;
    timeout   = 1'b0;
    fim_jogo  = 1'b0;
    case (r_estado)
      INICIAL: begin
        pronto = 1'b1;
        if (iniciar) w_proximo = PREPARA;
      end
      PREPARA: begin
        zera_t    = 1'b1;
        w_proximo = ESPERA;
      end
      ESPERA: begin
        // A move edge outranks an end-of-count seen in the same cycle
        conta_t = ~w_pausa;
        if (w_mov)                 w_proximo = REGISTRA;
        else if (fim_t & ~w_pausa) w_proximo = ESGOTADO;
      end
      REGISTRA: begin
        jogada_ok = 1'b1;
        w_proximo = PREPARA;
      end
      ESGOTADO: begin
        timeout = 1'b1;
        if (w_faltas_mais >= C_MAX) w_proximo = FIM_JOGO;
        else                        w_proximo = PREPARA;
      end
      FIM_JOGO: begin
        fim_jogo = 1'b1;
        if (iniciar) w_proximo = PREPARA;
      end
      default: w_proximo = INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado   <= INICIAL;
      r_jogada_d <= 1'b0;
      r_alerta   <= 1'b0;
      r_faltas   <= '0;
    end else begin
      r_estado   <= w_proximo;
      r_jogada_d <= jogada;
      // Cleared on entry so the warning already reads low while PREPARA clears the counter
      if (w_proximo == PREPARA)
        r_alerta <= 1'b0;
      else if ((r_estado == ESPERA) && meio_t)
        r_alerta <= 1'b1;
      if (w_reinicia)
        r_faltas <= '0;
      else if ((r_estado == ESGOTADO) && (w_faltas_mais <= C_MAX))
        r_faltas <= w_faltas_mais[NF-1:0];
    end
  end

  assign alerta    = r_alerta;
  assign faltas    = r_faltas;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_temporizador_jogada.sv
// Bench for temporizador_jogada with a modulo-m counter in the loop and a cycle-count reference model.
module tb_temporizador_jogada;

  localparam int MAXF = 3;
  localparam int NF   = 2;

  logic          clock   = 1'b0;
  logic          reset   = 1'b1;
  logic          iniciar = 1'b0;
  logic          jogada  = 1'b0;
  logic          pausa   = 1'b0;
  logic          fim_t, meio_t;
  logic          zera_t, conta_t, pronto, alerta, jogada_ok, timeout, fim_jogo;
  logic [NF-1:0] faltas;
  logic [2:0]    db_estado;

  int m      = 8;
  int q      = 0;
  int errors = 0;
  int checks = 0;
  int mf     = 0;

  temporizador_jogada #(.MAX_FALTAS(MAXF), .NF(NF)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .fim_t(fim_t), .meio_t(meio_t),
`ifdef TEMPORIZADOR_PAUSA_EN
    .pausa(pausa),
`endif
    .zera_t(zera_t), .conta_t(conta_t), .pronto(pronto), .alerta(alerta),
    .jogada_ok(jogada_ok), .timeout(timeout), .fim_jogo(fim_jogo),
    .faltas(faltas), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Modulo-m timing counter the controller drives
  always @(posedge clock) begin
    if (zera_t)       q <= 0;
    else if (conta_t) q <= (q == m - 1) ? 0 : q + 1;
  end
  assign fim_t  = (q == m - 1);
  assign meio_t = (q == m / 2 - 1);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic start();
    iniciar = 1'b1;
    tick();
    iniciar = 1'b0;
    #1;
    check("start_estado", db_estado, 1);
    check("start_zera", zera_t, 1);
    check("start_faltas", faltas, 0);
    check("start_alerta", alerta, 0);
    mf = 0;
  endtask

  // Entered while PREPARA is observed; k = ESPERA cycle of the move attempt, [ps, ps+pl) paused cycles
  task automatic run_move(input int k, input bit hold, input int ps, input int pl, output int nesp);
    int u;
    bit ok, done, al, paused, prev;
    check("prep_estado", db_estado, 1);
    check("prep_zera", zera_t, 1);
    check("prep_conta", conta_t, 0);
    check("prep_alerta", alerta, 0);
    u = 0; al = 0; ok = 0; done = 0; nesp = 0;
    while (!done && nesp < 100) begin
      tick();
      nesp++;
      paused  = (pl > 0) && (nesp >= ps) && (nesp < ps + pl);
      pausa   = paused;
      prev    = jogada;
      if (nesp == k) jogada = 1'b1;
      iniciar = 1'($urandom_range(0, 1));
      #1;
      check("esp_estado", db_estado, 2);
      check("esp_conta", conta_t, !paused);
      check("esp_alerta", alerta, al);
      if (jogada && !prev)            begin ok = 1; done = 1; end
      else if (!paused && u == m - 1) done = 1;
      if (u == m / 2 - 1) al = 1;
      if (!paused) u++;
    end
    if (!done) begin
      checks++;
      errors++;
      $error("FAIL esp_limite: observed %0d cycles without outcome, required at most %0d", nesp, m + pl);
    end
    tick();
    iniciar = 1'b0;
    pausa   = 1'b0;
    #1;
    check("saida_estado", db_estado, ok ? 3 : 4);
    check("saida_ok", jogada_ok, ok);
    check("saida_timeout", timeout, !ok);
    check("saida_alerta", alerta, al);
    check("saida_faltas", faltas, mf);
    check("saida_conta", conta_t, 0);
    if (!hold) jogada = 1'b0;
    if (!ok && mf < MAXF) mf++;
    tick();
    #1;
    check("pos_faltas", faltas, mf);
    check("pos_estado", db_estado, (mf == MAXF) ? 5 : 1);
    check("pos_fimjogo", fim_jogo, mf == MAXF);
    check("pos_alerta", alerta, (mf == MAXF) ? al : 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (2) @(negedge clock);
    #1;
    check("rst_estado", db_estado, 0);
    check("rst_pronto", pronto, 1);
    check("rst_alerta", alerta, 0);
    check("rst_faltas", faltas, 0);
    check("rst_conta", conta_t, 0);
    check("rst_zera", zera_t, 0);
    check("rst_pulsos", {jogada_ok, timeout, fim_jogo}, 0);
    reset = 1'b0;
    tick();
    #1;
    check("ocioso_estado", db_estado, 0);
    check("ocioso_pronto", pronto, 1);

    // Plain timeout with m = 8
    m = 8;
    start();
    run_move(100, 0, 0, 0, n);
    check("timeout_ciclos", n, 8);

    // Asynchronous reset in the middle of ESPERA
    repeat (6) tick();
    #1;
    check("pre_rst_estado", db_estado, 2);
    check("pre_rst_alerta", alerta, 1);
    check("pre_rst_faltas", faltas, 1);
    reset = 1'b1;
    #1;
    check("arst_estado", db_estado, 0);
    check("arst_pronto", pronto, 1);
    check("arst_alerta", alerta, 0);
    check("arst_faltas", faltas, 0);
    check("arst_conta", conta_t, 0);
    mf = 0;
    @(negedge clock);
    reset = 1'b0;
    #1;

    // Three timeouts end the game; restart clears misses
    start();
    for (int i = 0; i < 3; i++) begin
      m = 4 + 2 * $urandom_range(0, 3);
      run_move(100, 0, 0, 0, n);
    end
    check("fj_faltas", faltas, 3);
    tick();
    #1;
    check("fj_mantem", db_estado, 5);
    start();

    // Move on the fim_t cycle, then move on the meio_t cycle
    m = 8;
    run_move(8, 0, 0, 0, n);
    run_move(4, 0, 0, 0, n);

    // Held jogada gives one move only; a fresh rising edge is needed afterwards
    run_move(3, 1, 0, 0, n);
    run_move(100, 0, 0, 0, n);
    run_move(2, 0, 0, 0, n);

    for (int i = 0; i < 25; i++) begin
      if (mf == MAXF) start();
      m = 4 + 2 * $urandom_range(0, 3);
      run_move($urandom_range(1, m + 2), 1'($urandom_range(0, 1)), 0, 0, n);
    end
    jogada = 1'b0;

`ifdef TEMPORIZADOR_PAUSA_EN
    if (mf == MAXF) start();
    m = 8;
    run_move(100, 0, 3, 5, n);
    check("pausa_ciclos", n, 13);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/temporizador_jogada.md
# temporizador_jogada

- Per-move time-limit controller for the frog-jump game datapath.
- Sits directly upstream of the modulo-M timing counter: drives its synchronous clear and count-enable, and consumes its end-of-count and half-count flags.
- Converts those flags into a half-time warning, a timeout pulse or an accepted-move pulse.
- Tracks missed moves and ends the game after a configurable number of them.

## Interface
Parameters:
- MAX_FALTAS, 3 — number of timeouts that ends the game (≥1).
- NF, 2 — width of the miss counter; must hold MAX_FALTAS.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  start or restart request, level-sampled.
- jogada  in  1  player move, synchronous level; acted on at its rising edge only.
- fim_t  in  1  counter end-of-count flag (Q == M-1).
- meio_t  in  1  counter half-count flag (Q == M/2-1).
- zera_t  out  1  synchronous clear to the counter.
- conta_t  out  1  count enable to the counter.
- pronto  out  1  idle, waiting for iniciar.
- alerta  out  1  half-time warning for the current move.
- jogada_ok  out  1  one-cycle pulse: move accepted in time.
- timeout  out  1  one-cycle pulse: move time expired.
- fim_jogo  out  1  held high once MAX_FALTAS timeouts have occurred.
- faltas  out  NF  timeouts counted since the last start.
- db_estado  out  3  current state encoding.

## Operation
FSM states and encodings:
- INICIAL = 0:
  - Outputs: pronto = 1.
  - Transition: iniciar = 1 → PREPARA; faltas is cleared to 0 on that edge.
- PREPARA = 1:
  - Outputs: zera_t = 1; alerta is cleared.
  - Transition: unconditional → ESPERA.
- ESPERA = 2:
  - Outputs: conta_t = 1.
  - Transition priority:
    1. Move edge → REGISTRA.
    2. Otherwise fim_t = 1 → ESGOTADO.
    3. Otherwise stay in ESPERA.
  - meio_t = 1 sets alerta; alerta then holds until the next PREPARA, reset, or restart.
- REGISTRA = 3:
  - Outputs: jogada_ok = 1.
  - Transition: → PREPARA.
- ESGOTADO = 4:
  - Outputs: timeout = 1.
  - On the exit edge, faltas increments by 1.
  - Transition: if faltas+1 == MAX_FALTAS → FIM_JOGO, else → PREPARA.
- FIM_JOGO = 5:
  - Outputs: fim_jogo = 1.
  - Transition: iniciar = 1 → PREPARA, clearing faltas.
- Encodings 6 and 7 are illegal and recover to INICIAL on the next edge.

Move edge detection:
- Move edge is defined as jogada & ~jogada_d.
- jogada_d is registered every cycle in all states.
- A level held across PREPARA does not produce a second move.

Output style:
- zera_t, conta_t, pronto, jogada_ok, timeout, fim_jogo and db_estado are Moore (decoded from state only).
- alerta, faltas and jogada_d are registers.

Boundary behaviour:
- Move edge and fim_t in the same ESPERA cycle: the move wins, so jogada_ok is produced and no timeout.
- meio_t and a move edge in the same cycle: alerta is set and the move is still accepted; alerta clears in PREPARA.
- iniciar is ignored in PREPARA, ESPERA, REGISTRA and ESGOTADO.
- faltas saturates at MAX_FALTAS and never wraps.

## Timing
- Reset (asynchronous): state = INICIAL, alerta = 0, faltas = 0, jogada_d = 0; all Moore outputs take their INICIAL values (pronto = 1, all others 0).
- Reset asserted mid-move takes effect immediately, without a clock edge.
- iniciar to first conta_t: 2 edges (INICIAL → PREPARA → ESPERA).
- With a counter of modulus M cleared in PREPARA:
  - The first ESPERA cycle sees Q = 0.
  - fim_t is seen in the M-th ESPERA cycle.
  - timeout is high in the following cycle.
- Move edge to jogada_ok: 1 edge.
- jogada_ok/timeout to the next zera_t: 1 edge.
- Move-to-move turnaround: 2 cycles of non-counting (REGISTRA or ESGOTADO, then PREPARA).

## Configuration
- Macro: TEMPORIZADOR_PAUSA_EN.
- Defined:
  - Adds an input port pausa (1 bit).
  - While pausa = 1 in ESPERA: conta_t = 0 and fim_t is ignored.
  - Move edges are still accepted while paused.
  - alerta still latches on meio_t.
  - Other states are unaffected.
- Undefined:
  - pausa port is absent.
  - ESPERA always drives conta_t = 1.

## Test plan
- Reset during ESPERA with alerta = 1, faltas = 1 → immediately state 0, pronto = 1, alerta = 0, faltas = 0, conta_t = 0.
- iniciar, counter M = 8, no move → zera_t for 1 cycle, then conta_t for 8 cycles, alerta rising after meio_t (Q = 3), timeout pulse, faltas = 1, then PREPARA.
- Three consecutive timeouts with MAX_FALTAS = 3 → third timeout leads to state 5, fim_jogo = 1, faltas = 3; iniciar restarts with faltas = 0.
- Move edge on the same cycle as fim_t → jogada_ok = 1, timeout never asserts, faltas unchanged.
- jogada held high for 20 cycles → exactly one jogada_ok; the next move requires a low-then-high transition.
- With TEMPORIZADOR_PAUSA_EN, pausa = 1 for 5 cycles mid-ESPERA, M = 8 → conta_t = 0 during the pause; timeout arrives 5 cycles later than the unpaused case.
